// File: rtl/merge_control.sv
// merge_control -- decision unit of the 2-way streaming merger.
//
// Each cycle picks which input FIFO head (A or B) feeds the next 16-tuple
// block into the bitonic network. It also decides whether the pipeline
// stalls, and which half of the network output goes downstream.
//
// A block whose lowest tuple is all-zero terminates a run. Runs are merged
// pairwise up to their terminators. The terminator pair is then consumed
// over two cycles:
//   - A's terminator, while flushing the held larger half;
//   - then B's terminator.
//
// Ports:
//   i_clk            clock, state changes on rising edge
//   i_rst_n          synchronous active-low reset
//   i_fifo_out_full  downstream cannot accept a block this cycle
//   i_a_min_zero     FIFO A head is a terminator
//   i_b_min_zero     FIFO B head is a terminator
//   i_a_lte_b        key(A head lowest) <= key(B head lowest)
//   i_a_empty        FIFO A has no valid head
//   i_b_empty        FIFO B has no valid head
//   select_A         1 = dequeue/use A head, 0 = dequeue/use B head
//   stall            1 = no dequeue, pipeline holds
//   switch_output    1 = emit larger half of network output, 0 = smaller half
module merge_control (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_fifo_out_full,
  input  logic i_a_min_zero,
  input  logic i_b_min_zero,
  input  logic i_a_lte_b,
  input  logic i_a_empty,
  input  logic i_b_empty,
  output logic select_A,
  output logic stall,
  output logic switch_output
);

  typedef enum logic [0:0] {
    MERGE   = 1'b0,
    FLUSH_B = 1'b1
  } state_e;

  state_e state_q, state_d;

  // Outputs are combinational so the dequeue lands in the same cycle as the
  // decision; only the MERGE/FLUSH_B phase is registered.
  always_comb begin
    state_d       = state_q;
    select_A      = 1'b0;
    stall         = 1'b1;
    switch_output = 1'b0;

    if (!i_rst_n) begin
      // Outputs held at their safe values; any flush in progress is dropped.
      state_d = MERGE;
    end else begin
      case (state_q)
        MERGE: begin
          stall = i_fifo_out_full | i_a_empty | i_b_empty;
          if (i_a_min_zero && i_b_min_zero) begin
            // Both runs ended: take A's terminator and flush the held
            // larger half, then consume B's terminator next cycle.
            select_A      = 1'b1;
            switch_output = !stall;
            if (!stall) state_d = FLUSH_B;
          end else if (i_a_min_zero) begin
            select_A = 1'b0;
          end else if (i_b_min_zero) begin
            select_A = 1'b1;
          end else begin
            select_A = i_a_lte_b;
          end
        end

        FLUSH_B: begin
          // Only B's head matters here; A may be empty without stalling.
          stall = i_fifo_out_full | i_b_empty;
          if (!stall) state_d = MERGE;
        end

        default: state_d = MERGE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state_q <= MERGE;
    else          state_q <= state_d;
  end

endmodule

// File: tb/tb_merge_control.sv
// tb_merge_control -- directed testbench for merge_control.
// Each scenario task drives inputs, waits for the combinational outputs to
// settle, and compares {stall, select_A, switch_output} to hand-derived values.
// The internal state is inferred from how the outputs respond.
module tb_merge_control;

  logic clk;
  logic rst_n;
  logic full, az, bz, lte, ae, be;
  logic select_A, stall, switch_output;

  int pass_cnt  = 0;
  int total_cnt = 0;

  merge_control dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_fifo_out_full(full),
    .i_a_min_zero   (az),
    .i_b_min_zero   (bz),
    .i_a_lte_b      (lte),
    .i_a_empty      (ae),
    .i_b_empty      (be),
    .select_A       (select_A),
    .stall          (stall),
    .switch_output  (switch_output)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one input vector: full, a_zero, b_zero, a_lte_b, a_empty, b_empty.
  task automatic drive(input logic f, input logic a0, input logic b0,
                       input logic l, input logic e_a, input logic e_b);
    full = f; az = a0; bz = b0; lte = l; ae = e_a; be = e_b;
    #1;
  endtask

  // Move to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      total_cnt++;
      if ({stall, select_A, switch_output} !== 3'b100)
        $display("FAIL reset_hold_c%0d: got %b want %b", i, {stall, select_A, switch_output}, 3'b100);
      else pass_cnt++;
      step();
    end
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    total_cnt++;
    if ({stall, select_A, switch_output} !== 3'b010)
      $display("FAIL reset_release_merge: got %b want %b", {stall, select_A, switch_output}, 3'b010);
    else pass_cnt++;
    step();
  endtask

  task automatic test_compare();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    total_cnt++;
    if ({stall, select_A, switch_output} !== 3'b010)
      $display("FAIL compare_lte1: got %b want %b", {stall, select_A, switch_output}, 3'b010);
    else pass_cnt++;
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    total_cnt++;
    if ({stall, select_A, switch_output} !== 3'b000)
      $display("FAIL compare_lte0: got %b want %b", {stall, select_A, switch_output}, 3'b000);
    else pass_cnt++;
    step();
  endtask

  task automatic test_empty_full();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    total_cnt++;
    if ({stall, select_A, switch_output} !== 3'b110)
      $display("FAIL merge_b_empty: got %b want %b", {stall, select_A, switch_output}, 3'b110);
    else pass_cnt++;
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    total_cnt++;
    if ({stall, select_A, switch_output} !== 3'b100)
      $display("FAIL merge_a_empty: got %b want %b", {stall, select_A, switch_output}, 3'b100);
    else pass_cnt++;
    step();
    // Full while a terminator pair waits: must stall and stay in MERGE.
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      total_cnt++;
      if ({stall, select_A, switch_output} !== 3'b110)
        $display("FAIL full_hold_c%0d: got %b want %b", i, {stall, select_A, switch_output}, 3'b110);
      else pass_cnt++;
      step();
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    total_cnt++;
    if ({stall, select_A, switch_output} !== 3'b010)
      $display("FAIL full_state_held: got %b want %b", {stall, select_A, switch_output}, 3'b010);
    else pass_cnt++;
    step();
  endtask

  task automatic test_one_run();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      total_cnt++;
      if ({stall, select_A, switch_output} !== 3'b000)
        $display("FAIL a_done_c%0d: got %b want %b", i, {stall, select_A, switch_output}, 3'b000);
      else pass_cnt++;
      step();
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    total_cnt++;
    if ({stall, select_A, switch_output} !== 3'b010)
      $display("FAIL b_done: got %b want %b", {stall, select_A, switch_output}, 3'b010);
    else pass_cnt++;
    step();
  endtask

  task automatic test_terminator();
    // Cycle n: A's terminator with flush.
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    total_cnt++;
    if ({stall, select_A, switch_output} !== 3'b011)
      $display("FAIL term_n: got %b want %b", {stall, select_A, switch_output}, 3'b011);
    else pass_cnt++;
    step();
    // Cycle n+1: B's terminator. A empty must not stall here.
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    total_cnt++;
    if ({stall, select_A, switch_output} !== 3'b000)
      $display("FAIL term_n1: got %b want %b", {stall, select_A, switch_output}, 3'b000);
    else pass_cnt++;
    step();
    // Cycle n+2: back in MERGE.
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    total_cnt++;
    if ({stall, select_A, switch_output} !== 3'b010)
      $display("FAIL term_n2_merge: got %b want %b", {stall, select_A, switch_output}, 3'b010);
    else pass_cnt++;
    step();

    // Repeat, with B empty and then downstream full during FLUSH_B.
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    total_cnt++;
    if ({stall, select_A, switch_output} !== 3'b011)
      $display("FAIL term2_n: got %b want %b", {stall, select_A, switch_output}, 3'b011);
    else pass_cnt++;
    step();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
      total_cnt++;
      if ({stall, select_A, switch_output} !== 3'b100)
        $display("FAIL flush_b_empty_c%0d: got %b want %b", i, {stall, select_A, switch_output}, 3'b100);
      else pass_cnt++;
      step();
    end
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    total_cnt++;
    if ({stall, select_A, switch_output} !== 3'b100)
      $display("FAIL flush_full: got %b want %b", {stall, select_A, switch_output}, 3'b100);
    else pass_cnt++;
    step();
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    total_cnt++;
    if ({stall, select_A, switch_output} !== 3'b000)
      $display("FAIL flush_release: got %b want %b", {stall, select_A, switch_output}, 3'b000);
    else pass_cnt++;
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    total_cnt++;
    if ({stall, select_A, switch_output} !== 3'b010)
      $display("FAIL flush_back_merge: got %b want %b", {stall, select_A, switch_output}, 3'b010);
    else pass_cnt++;
    step();
  endtask

  task automatic test_back_to_back();
    for (int p = 0; p < 2; p++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      total_cnt++;
      if ({stall, select_A, switch_output} !== 3'b011)
        $display("FAIL b2b_pair%0d_a: got %b want %b", p, {stall, select_A, switch_output}, 3'b011);
      else pass_cnt++;
      step();
      total_cnt++;
      if ({stall, select_A, switch_output} !== 3'b000)
        $display("FAIL b2b_pair%0d_b: got %b want %b", p, {stall, select_A, switch_output}, 3'b000);
      else pass_cnt++;
      step();
    end
  endtask

  task automatic test_reset_mid_flush();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    total_cnt++;
    if ({stall, select_A, switch_output} !== 3'b100)
      $display("FAIL midflush_reset_out: got %b want %b", {stall, select_A, switch_output}, 3'b100);
    else pass_cnt++;
    step();
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    total_cnt++;
    if ({stall, select_A, switch_output} !== 3'b010)
      $display("FAIL midflush_abandoned: got %b want %b", {stall, select_A, switch_output}, 3'b010);
    else pass_cnt++;
    step();
  endtask

  initial begin
    test_reset();
    test_compare();
    test_empty_full();
    test_one_run();
    test_terminator();
    test_back_to_back();
    test_reset_mid_flush();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
